mul_seq: RTL and testbench
==========================

# mul_seq

Sequencer that borrows the 64-bit Am2901/Am2902/Am2904 datapath for an iterative shift-and-add multiply. While it owns the datapath, it drives every ALU and status/shift control field, one microinstruction per clock. Product high half ends in register `ACC_REG` and low half in the Q register. It sits beside the microprogram sequencer; `own` steers the datapath control mux to this block.

## Interface
Parameters:
- `MCAND_REG`, 4'd1: register-file address of the multiplicand, driven on `A`.
- `ACC_REG`, 4'd0: register-file address of the accumulator / high product, driven on `B`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: request a multiply; sampled only in IDLE.
- `abort` in 1: cancel the operation in progress.
- `mode32` in 1: 32-bit operation; also passed straight through to the datapath.
- `q_lsb` in 1: current Q[0] from the datapath (the Q0 shift line).
- `own` out 1: sequencer drives the datapath controls.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `d_load` out 1: requester must present the multiplier on D this cycle.
- `Ialu` out 9: ALU instruction.
- `A` out 4, `B` out 4: register addresses.
- `C0` out 1: ALU carry in.
- `Iss` out 13: status/shift instruction.
- `nCEM` out 1, `nCEN` out 1: status register enables, active-low.

## Operation
- States: IDLE, LOADQ, CLEAR, ITER, FINISH.
- IDLE → LOADQ on `start & !abort`. In every other state `start` is ignored.
- LOADQ:
  - `Ialu` = dest QREG, func R+S, src DZ, so Q ← D.
  - `d_load` = 1.
  - The iteration counter `cnt` (7 bits) loads 31 if `mode32`, else 63.
- CLEAR: `Ialu` = dest RAMF, func AND, src ZA, so ACC ← 0.
- ITER, one step per cycle, all steps with dest RAMQD (RAM and Q shift down):
  - `q_lsb`=1: func R+S, src AB, `C0`=0, so ACC ← (MCAND+ACC)>>1.
  - `q_lsb`=0: func R+S, src ZB, so ACC ← ACC>>1.
  - `Iss` selects the shift linkage: RAM MSB ← ALU carry out, Q MSB ← RAM LSB.
  - `cnt` decrements each step. On the step with `cnt`==0, go to FINISH (32 or 64 steps total).
- FINISH: `done`=1, `Ialu`=IDLE code, then return to IDLE.
- `own` = `busy` = (state != IDLE).
- `A`=`MCAND_REG` and `B`=`ACC_REG` whenever `own`; both 0 otherwise.
- `nCEN`=0 only in ITER; `nCEM`=1 always.
- `abort` in any non-IDLE state → IDLE next cycle. No `done` is issued; register contents are undefined.
- Width rule: in `mode32` the datapath's carry and shift linkage is taken at bit 31. The sequencer only changes the step count.

## Timing
- Reset values:
  - state IDLE, `cnt`=0.
  - `own`=`busy`=`done`=`d_load`=0.
  - `Ialu`=IALU_IDLE (dest NOP, func R+S, src ZA).
  - `A`=`B`=0, `C0`=0, `Iss`=ISS_IDLE.
  - `nCEM`=`nCEN`=1.
- All control outputs are combinational from state, `cnt` and `q_lsb`. The datapath registers them on the same edge the state advances.
- Latency: `start` sampled at edge k. `done` is high in cycle k+N+3 (N = 32 or 64). The product is valid in registers from the following edge.
- A new `start` is accepted in the cycle after `done`.
- `reset` mid-operation returns to IDLE immediately and asynchronously; outputs take their reset values.

## Configuration
- `MULSEQ_SIGNED_EN` defined: two's-complement multiply.
  - On the final ITER step with `q_lsb`=1: func S-R (ACC−MCAND), `C0`=1.
  - All ITER steps use the signed shift linkage: RAM MSB ← N xor OVR.
- Undefined: unsigned multiply only; no subtract step is ever issued.

## Structure
- Shared package `mulseq_pkg` holds:
  - Am2901 field enums: dest, func, src.
  - IALU_IDLE and ISS_IDLE.
  - ISS_MUL_U and ISS_MUL_S, taken from the Am2904 shift table.
  - The state enum.
- One sub-module, `mulseq_decode`: combinational mapping of (state, `q_lsb`, last step) to `Ialu`/`C0`/`Iss`.

## Test plan
- Unsigned 64-bit: MCAND=64'hFFFF_FFFF_FFFF_FFFF, D=64'h2 → ACC=64'h1, Q=64'hFFFF_FFFF_FFFF_FFFE. `done` pulses 67 cycles after `start`.
- `mode32`: MCAND=32'h0001_0000, D=32'h0001_0000 → ACC[31:0]=1, Q[31:0]=0. `done` comes at cycle 35.
- Signed, with `MULSEQ_SIGNED_EN`: MCAND=−3, D=5 → 128-bit result −15 (ACC=all ones, Q=64'hFFFF_FFFF_FFFF_FFF1).
- `abort` asserted in ITER at `cnt`=40 → IDLE next cycle, `done` never asserted, `own`=0.
- `start` during ITER is ignored; `start`+`abort` together in IDLE → stays IDLE.
- `reset` pulsed mid-ITER → all outputs at reset values in the same cycle. The next `start` runs a full, correct multiply.

Source files
------------

// File: rtl/mulseq_pkg.sv
// Shared Am2901/Am2904 control-field encodings, idle microwords and sequencer state for mul_seq.
package mulseq_pkg;

    typedef enum logic [2:0] {
        DEST_QREG  = 3'd0,
        DEST_NOP   = 3'd1,
        DEST_RAMA  = 3'd2,
        DEST_RAMF  = 3'd3,
        DEST_RAMQD = 3'd4,
        DEST_RAMD  = 3'd5,
        DEST_RAMQU = 3'd6,
        DEST_RAMU  = 3'd7
    } alu_dest_t;

    typedef enum logic [2:0] {
        FUNC_ADD   = 3'd0,
        FUNC_SUBR  = 3'd1,
        FUNC_SUBS  = 3'd2,
        FUNC_OR    = 3'd3,
        FUNC_AND   = 3'd4,
        FUNC_NOTRS = 3'd5,
        FUNC_EXOR  = 3'd6,
        FUNC_EXNOR = 3'd7
    } alu_func_t;

    typedef enum logic [2:0] {
        SRC_AQ = 3'd0,
        SRC_AB = 3'd1,
        SRC_ZQ = 3'd2,
        SRC_ZB = 3'd3,
        SRC_ZA = 3'd4,
        SRC_DA = 3'd5,
        SRC_DQ = 3'd6,
        SRC_DZ = 3'd7
    } alu_src_t;

    // Am2901 I8..I0 microword: destination, function, source.
    typedef struct packed {
        alu_dest_t dest;
        alu_func_t func;
        alu_src_t  src;
    } ialu_t;

    // Am2904 I12..I0: carry-in select, shift linkage, status-register operation.
    typedef struct packed {
        logic [1:0] carry_sel;
        logic [4:0] shift;
        logic [5:0] status;
    } iss_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADQ  = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_ITER   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int CNT_W = 7;
    localparam logic [CNT_W-1:0] CNT_LOAD_64 = 7'd63;
    localparam logic [CNT_W-1:0] CNT_LOAD_32 = 7'd31;

    localparam logic [4:0] SHIFT_NONE       = 5'b00000;
    localparam logic [4:0] SHIFT_DN_CARRY   = 5'b01010;
    localparam logic [4:0] SHIFT_DN_N_X_OVR = 5'b01110;
    localparam logic [5:0] STATUS_HOLD      = 6'b000000;
    localparam logic [5:0] STATUS_LOAD_ALU  = 6'b001010;

    localparam ialu_t IALU_IDLE = '{dest: DEST_NOP, func: FUNC_ADD, src: SRC_ZA};

    localparam iss_t ISS_IDLE  = '{carry_sel: 2'b00, shift: SHIFT_NONE,       status: STATUS_HOLD};
    localparam iss_t ISS_MUL_U = '{carry_sel: 2'b00, shift: SHIFT_DN_CARRY,   status: STATUS_LOAD_ALU};
    localparam iss_t ISS_MUL_S = '{carry_sel: 2'b00, shift: SHIFT_DN_N_X_OVR, status: STATUS_LOAD_ALU};

    function automatic ialu_t alu_op(input alu_dest_t dest, input alu_func_t func, input alu_src_t src);
        ialu_t word;
        word.dest = dest;
        word.func = func;
        word.src  = src;
        return word;
    endfunction

endpackage

// File: rtl/mulseq_decode.sv
// Maps sequencer state, Q0 and the last-step flag onto Am2901/Am2904 microword fields.
// MULSEQ_SIGNED_EN selects two's-complement steps (final subtract, N xor OVR linkage).
module mulseq_decode
    import mulseq_pkg::*;
(
    input  state_t      state,
    input  logic        q_lsb,
    input  logic        last_step,
    output logic [8:0]  ialu,
    output logic        c0,
    output logic [12:0] iss
);

    ialu_t word;
    iss_t  shift_ctl;

    always_comb begin
        word      = IALU_IDLE;
        c0        = 1'b0;
        shift_ctl = ISS_IDLE;
        case (state)
            ST_LOADQ: word = alu_op(DEST_QREG, FUNC_ADD, SRC_DZ);
            ST_CLEAR: word = alu_op(DEST_RAMF, FUNC_AND, SRC_ZA);
            ST_ITER: begin
`ifdef MULSEQ_SIGNED_EN
                shift_ctl = ISS_MUL_S;
                // The multiplier's sign bit carries negative weight, so its partial product is subtracted.
                if (q_lsb && last_step) begin
                    word = alu_op(DEST_RAMQD, FUNC_SUBR, SRC_AB);
                    c0   = 1'b1;
                end else if (q_lsb) begin
                    word = alu_op(DEST_RAMQD, FUNC_ADD, SRC_AB);
                end else begin
                    word = alu_op(DEST_RAMQD, FUNC_ADD, SRC_ZB);
                end
`else
                shift_ctl = ISS_MUL_U;
                if (q_lsb) begin
                    word = alu_op(DEST_RAMQD, FUNC_ADD, SRC_AB);
                end else begin
                    word = alu_op(DEST_RAMQD, FUNC_ADD, SRC_ZB);
                end
`endif
            end
            default: word = IALU_IDLE;
        endcase
    end

`ifndef MULSEQ_SIGNED_EN
    logic unused_last_step;
    assign unused_last_step = last_step;
`endif

    assign ialu = word;
    assign iss  = shift_ctl;

endmodule

// File: rtl/mul_seq.sv
// mul_seq: borrows the Am2901/2902/2904 datapath for an iterative shift-and-add multiply.
// Optional MULSEQ_SIGNED_EN build gives a two's-complement multiply (see mulseq_decode).
module mul_seq
    import mulseq_pkg::*;
#(
    parameter logic [3:0] MCAND_REG = 4'd1,
    parameter logic [3:0] ACC_REG   = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        mode32,
    input  logic        q_lsb,
    output logic        own,
    output logic        busy,
    output logic        done,
    output logic        d_load,
    output logic [8:0]  Ialu,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic        C0,
    output logic [12:0] Iss,
    output logic        nCEM,
    output logic        nCEN
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic [8:0]       ialu_dec;
    logic [12:0]      iss_dec;
    logic             c0_dec;

    assign last_step = (state == ST_ITER) && (cnt == '0);

    // Abort wins over every transition; the datapath contents are simply abandoned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) state <= ST_LOADQ;
                end
                ST_LOADQ: begin
                    cnt   <= mode32 ? CNT_LOAD_32 : CNT_LOAD_64;
                    state <= ST_CLEAR;
                end
                ST_CLEAR: state <= ST_ITER;
                ST_ITER: begin
                    cnt <= cnt - 7'd1;
                    if (cnt == '0) state <= ST_FINISH;
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    mulseq_decode u_decode (
        .state     (state),
        .q_lsb     (q_lsb),
        .last_step (last_step),
        .ialu      (ialu_dec),
        .c0        (c0_dec),
        .iss       (iss_dec)
    );

    // Outputs stay combinational so the datapath registers them on the edge the state advances.
    always_comb begin
        own    = (state != ST_IDLE);
        busy   = own;
        done   = (state == ST_FINISH);
        d_load = (state == ST_LOADQ);
        A      = own ? MCAND_REG : 4'd0;
        B      = own ? ACC_REG : 4'd0;
        Ialu   = ialu_dec;
        C0     = c0_dec;
        Iss    = iss_dec;
        nCEM   = 1'b1;
        nCEN   = (state != ST_ITER);
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a behavioural Am2901 datapath executes the emitted microwords
// and products are compared against plain arithmetic multiplication.
module tb_mul_seq;
    import mulseq_pkg::*;

`ifdef MULSEQ_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode32 = 1'b0;
    logic        q_lsb;
    logic        own, busy, done, d_load, C0, nCEM, nCEN;
    logic [8:0]  Ialu;
    logic [3:0]  A, B;
    logic [12:0] Iss;

    int checks = 0;
    int errors = 0;

    logic [63:0] dp_acc = '0;
    logic [63:0] dp_q = '0;
    logic [63:0] dp_mcand = '0;
    logic [63:0] d_bus = '0;
    int          dp_bad = 0;

    int          r_lat, r_iter, r_dload, r_c0, r_ctlbad;
    logic [63:0] r_acc, r_q;

    localparam logic [36:0] RESET_OUTS = {4'b0000, 9'b001_000_100, 4'd0, 4'd0, 1'b0, 13'd0, 1'b1, 1'b1};

    mul_seq #(.MCAND_REG(4'd1), .ACC_REG(4'd0)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode32(mode32), .q_lsb(q_lsb),
        .own(own), .busy(busy), .done(done), .d_load(d_load), .Ialu(Ialu), .A(A), .B(B),
        .C0(C0), .Iss(Iss), .nCEM(nCEM), .nCEN(nCEN)
    );

    always #5 clk = ~clk;

    assign q_lsb = dp_q[0];

    function automatic logic [36:0] outs();
        return {own, busy, done, d_load, Ialu, A, B, C0, Iss, nCEM, nCEN};
    endfunction

    function automatic logic [63:0] reg_read(input logic [3:0] addr);
        if (addr == 4'd0) return dp_acc;
        if (addr == 4'd1) return dp_mcand;
        return 64'd0;
    endfunction

    // Expected full-width product, zero-extended for 32-bit operation.
    function automatic logic [127:0] ref_product(input logic [63:0] a, input logic [63:0] b, input bit m32);
        logic signed [127:0] sa, sb;
        logic signed [63:0]  sa32, sb32;
        if (m32) begin
            if (SIGNED_BUILD) begin
                sa32 = {{32{a[31]}}, a[31:0]};
                sb32 = {{32{b[31]}}, b[31:0]};
                return {64'd0, 64'(sa32 * sb32)};
            end
            return {64'd0, 64'({32'd0, a[31:0]} * {32'd0, b[31:0]})};
        end
        if (SIGNED_BUILD) begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
            return 128'(sa * sb);
        end
        return {64'd0, a} * {64'd0, b};
    endfunction

    function automatic logic [127:0] got_product(input bit m32);
        if (m32) return {64'd0, r_acc[31:0], r_q[31:0]};
        return {r_acc, r_q};
    endfunction

    // Behavioural Am2901 datapath honouring the Am2904 shift linkage selected by Iss.
    always @(posedge clk) begin : datapath_model
        logic [63:0] mask, r, s, y, f, shifted;
        logic [64:0] sum;
        logic        c_out, ovr, neg, msb_in;
        int          msb;
        if (!reset && own) begin
            msb  = mode32 ? 31 : 63;
            mask = mode32 ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
            case (Ialu[2:0])
                3'd0: begin r = reg_read(A); s = dp_q; end
                3'd1: begin r = reg_read(A); s = reg_read(B); end
                3'd2: begin r = '0; s = dp_q; end
                3'd3: begin r = '0; s = reg_read(B); end
                3'd4: begin r = '0; s = reg_read(A); end
                3'd5: begin r = d_bus; s = reg_read(A); end
                3'd6: begin r = d_bus; s = dp_q; end
                default: begin r = d_bus; s = '0; end
            endcase
            r = r & mask;
            s = s & mask;
            c_out = 1'b0;
            ovr = 1'b0;
            f = '0;
            case (Ialu[5:3])
                3'd0, 3'd1: begin
                    y     = (Ialu[5:3] == 3'd1) ? (~r & mask) : r;
                    sum   = {1'b0, s} + {1'b0, y} + {64'd0, C0};
                    f     = sum[63:0] & mask;
                    c_out = sum[msb+1];
                    ovr   = (s[msb] == y[msb]) && (f[msb] != s[msb]);
                end
                3'd4: f = r & s;
                default: dp_bad <= dp_bad + 1;
            endcase
            neg = f[msb];
            case (Ialu[8:6])
                3'd0: dp_q <= f;
                3'd1: ;
                3'd3: begin
                    if (B == 4'd0) dp_acc <= f;
                    else dp_bad <= dp_bad + 1;
                end
                3'd4: begin
                    msb_in  = (Iss == ISS_MUL_S) ? (neg ^ ovr) : ((Iss == ISS_MUL_U) ? c_out : 1'b0);
                    shifted = (f >> 1) | (64'(msb_in) << msb);
                    if (B == 4'd0) dp_acc <= shifted;
                    else dp_bad <= dp_bad + 1;
                    dp_q <= ((dp_q & mask) >> 1) | (64'(f[0]) << msb);
                end
                default: dp_bad <= dp_bad + 1;
            endcase
        end
    end

    // Starts one multiply and records what the run looked like; poke_at pulses start mid-run.
    task automatic run_multiply(input logic [63:0] mc, input logic [63:0] mp, input bit m32, input int poke_at);
        bit seen;
        @(negedge clk);
        dp_mcand = mc;
        d_bus    = mp;
        mode32   = m32;
        start    = 1'b1;
        @(posedge clk);
        r_lat = 1; r_iter = 0; r_dload = 0; r_c0 = 0; r_ctlbad = 0;
        seen = 1'b0;
        while (!seen && r_lat <= 200) begin
            @(negedge clk);
            start = (r_lat == poke_at);
            if (d_load) r_dload++;
            if (!nCEN) r_iter++;
            if (C0) r_c0++;
            if (!own || !busy || A != 4'd1 || B != 4'd0 || !nCEM) r_ctlbad++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                r_lat++;
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        r_acc = dp_acc;
        r_q   = dp_q;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", outs(), RESET_OUTS);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got %h want %h", outs(), RESET_OUTS);
        end
    endtask

    task automatic test_unsigned_directed();
        logic [127:0] exp_p;
        exp_p = SIGNED_BUILD ? {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE}
                             : {64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE};
        run_multiply(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 0);
        checks++;
        if (got_product(1'b0) !== exp_p) begin
            errors++;
            $display("[TB] FAIL dir64_product got %h want %h", got_product(1'b0), exp_p);
        end
        checks++;
        if (r_lat != 67) begin
            errors++;
            $display("[TB] FAIL dir64_latency got %0d want 67", r_lat);
        end
        checks++;
        if (r_iter != 64 || r_dload != 1 || r_c0 != 0 || r_ctlbad != 0) begin
            errors++;
            $display("[TB] FAIL dir64_control iter %0d dload %0d c0 %0d ctlbad %0d want 64 1 0 0",
                     r_iter, r_dload, r_c0, r_ctlbad);
        end
    endtask

    task automatic test_mode32_directed();
        run_multiply(64'hDEAD_BEEF_0001_0000, 64'hCAFE_F00D_0001_0000, 1'b1, 0);
        checks++;
        if (got_product(1'b1) !== 128'h1_0000_0000) begin
            errors++;
            $display("[TB] FAIL dir32_product got %h want %h", got_product(1'b1), 128'h1_0000_0000);
        end
        checks++;
        if (r_lat != 35) begin
            errors++;
            $display("[TB] FAIL dir32_latency got %0d want 35", r_lat);
        end
        checks++;
        if (r_iter != 32 || r_dload != 1 || r_c0 != 0 || r_ctlbad != 0) begin
            errors++;
            $display("[TB] FAIL dir32_control iter %0d dload %0d c0 %0d ctlbad %0d want 32 1 0 0",
                     r_iter, r_dload, r_c0, r_ctlbad);
        end
    endtask

    task automatic test_random();
        logic [63:0]  mc, mp;
        logic [127:0] exp_p;
        bit           m32;
        int           n, exp_c0;
        for (int i = 0; i < 8; i++) begin
            mc  = {$urandom, $urandom};
            mp  = {$urandom, $urandom};
            m32 = (i % 2 == 1);
            if (i == 2) mp[63] = 1'b1;
            if (i == 3) mp[31] = 1'b1;
            n      = m32 ? 32 : 64;
            exp_p  = ref_product(mc, mp, m32);
            exp_c0 = (SIGNED_BUILD && mp[n-1]) ? 1 : 0;
            run_multiply(mc, mp, m32, 0);
            checks++;
            if (got_product(m32) !== exp_p) begin
                errors++;
                $display("[TB] FAIL rand%0d_product mc %h mp %h got %h want %h", i, mc, mp, got_product(m32), exp_p);
            end
            checks++;
            if (r_lat != n + 3 || r_iter != n || r_dload != 1 || r_c0 != exp_c0 || r_ctlbad != 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_timing lat %0d iter %0d dload %0d c0 %0d ctlbad %0d want %0d %0d 1 %0d 0",
                         i, r_lat, r_iter, r_dload, r_c0, r_ctlbad, n + 3, n, exp_c0);
            end
        end
    endtask

`ifdef MULSEQ_SIGNED_EN
    task automatic test_signed();
        run_multiply(-64'sd3, 64'sd5, 1'b0, 0);
        checks++;
        if (got_product(1'b0) !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1}) begin
            errors++;
            $display("[TB] FAIL signed_m3x5 got %h want all-ones:FFFFFFFFFFFFFFF1", got_product(1'b0));
        end
        run_multiply(64'sd7, -64'sd9, 1'b0, 0);
        checks++;
        if (got_product(1'b0) !== 128'(-128'sd63) || r_c0 != 1) begin
            errors++;
            $display("[TB] FAIL signed_7xm9 got %h c0 %0d want %h c0 1", got_product(1'b0), r_c0, 128'(-128'sd63));
        end
    endtask
`endif

    task automatic test_abort();
        int done_seen;
        @(negedge clk);
        dp_mcand = {$urandom, $urandom};
        d_bus    = {$urandom, $urandom};
        mode32   = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        checks++;
        if (nCEN !== 1'b0 || own !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_in_iter nCEN %b own %b want 0 1", nCEN, own);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++;
            $display("[TB] FAIL abort_to_idle got %h want %h", outs(), RESET_OUTS);
        end
        done_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || own) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done got %0d busy/done cycles want 0", done_seen);
        end
    endtask

    task automatic test_start_ignored();
        logic [63:0] mc, mp;
        mc = {$urandom, $urandom};
        mp = {$urandom, $urandom};
        run_multiply(mc, mp, 1'b0, 30);
        checks++;
        if (got_product(1'b0) !== ref_product(mc, mp, 1'b0) || r_lat != 67) begin
            errors++;
            $display("[TB] FAIL start_in_iter got %h lat %0d want %h lat 67", got_product(1'b0), r_lat,
                     ref_product(mc, mp, 1'b0));
        end
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (own !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_abort_idle own %b busy %b want 0 0", own, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] mc, mp;
        @(negedge clk);
        d_bus  = {$urandom, $urandom};
        mode32 = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs got %h want %h", outs(), RESET_OUTS);
        end
        @(negedge clk);
        reset = 1'b0;
        mc = {$urandom, $urandom};
        mp = {$urandom, $urandom};
        run_multiply(mc, mp, 1'b0, 0);
        checks++;
        if (got_product(1'b0) !== ref_product(mc, mp, 1'b0) || r_lat != 67) begin
            errors++;
            $display("[TB] FAIL reset_mid_rerun got %h lat %0d want %h lat 67", got_product(1'b0), r_lat,
                     ref_product(mc, mp, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] mc, mp;
        for (int i = 0; i < 2; i++) begin
            mc = {$urandom, $urandom};
            mp = {$urandom, $urandom};
            run_multiply(mc, mp, 1'b1, 0);
            checks++;
            if (got_product(1'b1) !== ref_product(mc, mp, 1'b1) || r_lat != 35) begin
                errors++;
                $display("[TB] FAIL b2b%0d got %h lat %0d want %h lat 35", i, got_product(1'b1), r_lat,
                         ref_product(mc, mp, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_directed();
        test_mode32_directed();
        test_random();
`ifdef MULSEQ_SIGNED_EN
        test_signed();
`endif
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (dp_bad != 0) begin
            errors++;
            $display("[TB] FAIL datapath_decode got %0d unexpected microwords want 0", dp_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
